// File: rtl/process_alloc_arbiter.sv
// Round-robin arbiter granting four cores exclusive use of one process allocator.
// Optional watchdog: define PROCESS_ALLOC_ARBITER_TIMEOUT_EN to abort hung RUN periods.
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

module process_alloc_arbiter #(
  parameter int addrBits = `ADDRESS_BITS,
  parameter int dataBits = `DATA_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            reqValid,
  input  logic [3:0]            reqCreate,
  input  logic [4*addrBits-1:0] reqWordsToCopy,
  input  logic [4*9-1:0]        reqStartPC,
  input  logic [4*addrBits-1:0] reqPidToFree,
  output logic [3:0]            reqDone,
  output logic [addrBits-1:0]   respPid,
  output logic                  respError,
  output logic [1:0]            grantId,
  output logic                  busy,
  output logic                  allocEnabled,
  output logic                  allocHasProcessCreate,
  output logic [addrBits-1:0]   allocWordsToCopy,
  output logic [8:0]            allocStartPC,
  output logic [addrBits-1:0]   allocPidToFree,
  input  logic                  allocFinished,
  input  logic [addrBits-1:0]   allocNewPid
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // dataBits only documents the allocator's data width; no data passes through here.
  if (dataBits < 1) begin : g_bad_data_bits
    $error("dataBits must be positive");
  end

  logic [1:0]          state_q, state_d;
  logic [1:0]          last_q, last_d;
  logic [3:0]          mask_q, mask_d;
  logic [1:0]          gid_q, gid_d;
  logic                busy_q, busy_d;
  logic                en_q, en_d;
  logic [3:0]          done_q, done_d;
  logic [addrBits-1:0] pid_q, pid_d;
  logic                create_q, create_d;
  logic [addrBits-1:0] words_q, words_d;
  logic [8:0]          pc_q, pc_d;
  logic [addrBits-1:0] free_q, free_d;
  logic                timed_out;

  logic [3:0] elig;
  logic       win_vld;
  logic [1:0] win_id;
  logic [1:0] idx;

  // Scan from the requester after the last served one, first eligible wins.
  always_comb begin
    elig    = reqValid & ~mask_q;
    win_vld = 1'b0;
    win_id  = 2'd0;
    idx     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = last_q + 2'(k + 1);
      if (!win_vld && elig[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    mask_d   = mask_q;
    gid_d    = gid_q;
    busy_d   = busy_q;
    en_d     = en_q;
    done_d   = 4'b0000;
    pid_d    = pid_q;
    create_d = create_q;
    words_d  = words_q;
    pc_d     = pc_q;
    free_d   = free_q;
    case (state_q)
      S_IDLE: begin
        mask_d = 4'b0000;
        if (win_vld) begin
          state_d  = S_RUN;
          gid_d    = win_id;
          busy_d   = 1'b1;
          en_d     = 1'b1;
          create_d = reqCreate[win_id];
          words_d  = reqWordsToCopy[win_id*addrBits +: addrBits];
          pc_d     = reqStartPC[win_id*9 +: 9];
          free_d   = reqPidToFree[win_id*addrBits +: addrBits];
        end
      end
      S_RUN: begin
        if (allocFinished || timed_out) begin
          state_d = S_DONE;
          en_d    = 1'b0;
          done_d  = 4'b0001 << gid_q;
          pid_d   = timed_out ? '0 : allocNewPid;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        last_d  = gid_q;
        // A core still holding reqValid in the cycle after its done pulse must not re-win.
        mask_d  = 4'b0001 << gid_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      last_q   <= 2'd3;
      mask_q   <= 4'b0000;
      gid_q    <= 2'd0;
      busy_q   <= 1'b0;
      en_q     <= 1'b0;
      done_q   <= 4'b0000;
      pid_q    <= '0;
      create_q <= 1'b0;
      words_q  <= '0;
      pc_q     <= '0;
      free_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      mask_q   <= mask_d;
      gid_q    <= gid_d;
      busy_q   <= busy_d;
      en_q     <= en_d;
      done_q   <= done_d;
      pid_q    <= pid_d;
      create_q <= create_d;
      words_q  <= words_d;
      pc_q     <= pc_d;
      free_q   <= free_d;
    end
  end

`ifdef PROCESS_ALLOC_ARBITER_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // Counter holds k-1 in the k-th RUN cycle, so the 255th RUN cycle ends the wait.
  assign timed_out = (state_q == S_RUN) && !allocFinished && (cnt_q == 8'hFE);

  always_comb begin
    cnt_d = (state_q == S_RUN) ? cnt_q + 8'd1 : 8'd0;
    err_d = err_q;
    if (state_q == S_RUN && (allocFinished || timed_out)) err_d = timed_out;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign respError = err_q;
`else
  assign timed_out = 1'b0;
  assign respError = 1'b0;
`endif

  assign reqDone               = done_q;
  assign respPid               = pid_q;
  assign grantId               = gid_q;
  assign busy                  = busy_q;
  assign allocEnabled          = en_q;
  assign allocHasProcessCreate = create_q;
  assign allocWordsToCopy      = words_q;
  assign allocStartPC          = pc_q;
  assign allocPidToFree        = free_q;
endmodule

// File: doc/process_alloc_arbiter.md
PROCESS_ALLOC_ARBITER -- requirements
Module: process_alloc_arbiter

Interface
REQ-001 SHALL have parameter addrBits, default `ADDRESS_BITS (8), address/PID width.
REQ-002 SHALL have parameter dataBits, default `DATA_BITS (16), data width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 reqValid  input  4  per-requester (core 0..3) request, held high until reqDone.
REQ-006 reqCreate  input  4  per-requester op: 1 = process create, 0 = process free.
REQ-007 reqWordsToCopy  input  4*addrBits  per-requester words to copy; slice i = requester i.
REQ-008 reqStartPC  input  4*9  per-requester start program counter.
REQ-009 reqPidToFree  input  4*addrBits  per-requester PID to free.
REQ-010 reqDone  output  4  one-hot, one-cycle completion pulse to the served requester.
REQ-011 respPid  output  addrBits  new PID; valid only while reqDone is non-zero.
REQ-012 respError  output  1  timeout flag; valid only while reqDone is non-zero.
REQ-013 grantId  output  2  index of the requester owning the allocator; valid while busy.
REQ-014 busy  output  1  high from grant until the DONE cycle inclusive.
REQ-015 allocEnabled  output  1  drives the allocator's enable; low resets the allocator.
REQ-016 allocHasProcessCreate, allocWordsToCopy[addrBits], allocStartPC[9], allocPidToFree[addrBits]  outputs  latched copy of the granted request.
REQ-017 allocFinished  input  1  allocator finished, held high while it stays enabled.
REQ-018 allocNewPid  input  addrBits  allocator's new PID.

Function
REQ-019 SHALL implement states IDLE, RUN, DONE, all registered.
REQ-020 IDLE: when any unmasked reqValid bit is high, SHALL pick the winner by round-robin starting at (lastServed+1) mod 4, latch its op fields, set grantId and busy, and go to RUN on the next edge.
REQ-021 RUN: allocEnabled SHALL be 1; the allocator inputs SHALL stay constant for the whole RUN period.
REQ-022 RUN: on allocFinished=1, SHALL capture allocNewPid into respPid, set respError=0 and go to DONE.
REQ-023 DONE: SHALL last exactly 1 cycle with allocEnabled=0, reqDone[grantId]=1, and update lastServed=grantId; then go to IDLE.
REQ-024 allocEnabled SHALL be low for at least one cycle (DONE) between consecutive transactions, so the allocator is reset to its initial state.
REQ-025 In the IDLE cycle immediately after DONE, the just-served requester's reqValid SHALL be masked (stale-request protection); all other requesters remain eligible.
REQ-026 Minimum overhead SHALL be 1 cycle IDLE->RUN plus 1 DONE cycle; a back-to-back grant SHALL occur in the IDLE cycle after DONE.
REQ-027 For a free op (reqCreate=0), respPid SHALL equal allocNewPid as sampled; requesters ignore it.
REQ-028 If reqValid for the granted requester drops during RUN, SHALL still complete the transaction and pulse reqDone.
REQ-029 Simultaneous requests SHALL be served in round-robin order; no requester waits more than 3 other transactions.

Reset
REQ-030 On reset=0, SHALL go immediately to IDLE: allocEnabled=0, reqDone=0, busy=0, grantId=0, respPid=0, respError=0, lastServed=3 (requester 0 first), mask cleared, latched op fields 0.
REQ-031 Reset during RUN SHALL abort with no reqDone pulse.

Configuration
REQ-032 Macro PROCESS_ALLOC_ARBITER_TIMEOUT_EN: when defined, an 8-bit counter SHALL clear on entry to RUN and increment each RUN cycle; if it reaches 255 without allocFinished, SHALL go to DONE with respError=1 and respPid=0.
REQ-033 Without PROCESS_ALLOC_ARBITER_TIMEOUT_EN, no counter SHALL exist, respError SHALL be constant 0, and RUN SHALL wait indefinitely.

Verification
REQ-034 Requester 2 create, WordsToCopy=3, StartPC=0x40; allocator finishes after 12 cycles with PID 5 -> allocWordsToCopy=3 and allocStartPC=0x40 during RUN; reqDone=4'b0100, respPid=5, respError=0.
REQ-035 All four reqValid high from reset, each held until done -> grants in order 0,1,2,3; allocEnabled low for one cycle between each grant.
REQ-036 Requester 1 free, PidToFree=7 -> allocHasProcessCreate=0, allocPidToFree=7; reqDone=4'b0010 one cycle after allocFinished.
REQ-037 Requester 0 keeps reqValid high for one cycle after its reqDone -> no second grant to requester 0 in that cycle.
REQ-038 reset asserted mid-RUN -> allocEnabled=0 and busy=0 immediately, no reqDone; the next request is granted normally.
REQ-039 With TIMEOUT_EN, allocFinished is never asserted -> reqDone after 255 RUN cycles with respError=1 and respPid=0.
